// File: rtl/mux_rr_arbiter_pkg.sv
// Shared helpers for the round-robin mux arbiter and its picker.
//   id_width(n)      : index width for n requesters, never below 1
//   next_idx(ptr, n) : ptr + 1 wrapped modulo n
package mux_rr_arbiter_pkg;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  function automatic int unsigned next_idx(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set req bit at
// index ptr, ptr+1, ... wrapping modulo N.
//   req    [N-1:0]   request vector
//   ptr    [IDW-1:0] highest-priority index
//   winner [IDW-1:0] chosen index (0 when nothing is requested)
//   any              at least one request present
module rr_pick
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] winner,
  output logic           any
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[IDW'((32'(ptr) + i - 32'd1) % N)]) begin
        winner = IDW'((32'(ptr) + i - 32'd1) % N);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// N:1 round-robin arbitrated mux with one output register stage.
// Optional packet lock enabled by macro MUX_RR_ARBITER_PACKET_LOCK_EN.
//   clk, rst             clock, synchronous active-high reset
//   in_valid  [N-1:0]    per-requester valid
//   in_data   [N*W-1:0]  requester k at [k*W +: W]
//   in_last   [N-1:0]    end-of-packet marker (lock build only)
//   in_ready  [N-1:0]    one-hot or zero grant
//   out_valid            output register holds a word
//   out_data  [W-1:0]    output word
//   out_ready            consumer accepts the word
//   out_id    [IDW-1:0]  requester that produced out_data
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               in_valid,
  input  logic [N*W-1:0]             in_data,
`ifdef MUX_RR_ARBITER_PACKET_LOCK_EN
  input  logic [N-1:0]               in_last,
`endif
  output logic [N-1:0]               in_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  input  logic                       out_ready,
  output logic [id_width(N)-1:0]     out_id
);

  localparam int unsigned IDW = id_width(N);
  localparam int unsigned SW  = id_width(N * W);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           any_req;
  logic           can_load;
  logic           xfer;
  logic [N-1:0]   req;
  logic [SW-1:0]  sel_base;

`ifdef MUX_RR_ARBITER_PACKET_LOCK_EN
  logic           locked;
  logic [IDW-1:0] lock_idx;

  // While a packet is open only its owner may be considered.
  always_comb begin
    req = in_valid;
    if (locked) begin
      req = in_valid & (N'(1) << lock_idx);
    end
  end
`else
  always_comb begin
    req = in_valid;
  end
`endif

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .any    (any_req)
  );

  // Stage can take a word when empty or draining this cycle.
  always_comb begin
    can_load = !out_valid || out_ready;
    xfer     = any_req && can_load;
    sel_base = SW'(32'(win) * W);
    in_ready = '0;
    if (xfer) begin
      in_ready[win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
`ifdef MUX_RR_ARBITER_PACKET_LOCK_EN
      locked    <= 1'b0;
      lock_idx  <= '0;
`endif
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[sel_base +: W];
        out_id    <= win;
`ifdef MUX_RR_ARBITER_PACKET_LOCK_EN
        // Pointer only moves once the packet closes.
        if (in_last[win]) begin
          locked <= 1'b0;
          ptr    <= IDW'(next_idx(32'(win), N));
        end else begin
          locked   <= 1'b1;
          lock_idx <= win;
        end
`else
        ptr       <= IDW'(next_idx(32'(win), N));
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [1:0]  out_id;
`ifdef MUX_RR_ARBITER_PACKET_LOCK_EN
  logic [3:0]  in_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef MUX_RR_ARBITER_PACKET_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_id    (out_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b0000; in_data = 32'h0; out_ready = 1'b0;
`ifdef MUX_RR_ARBITER_PACKET_LOCK_EN
    in_last = 4'b1111;
`endif
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_id !== 2'd0 || out_data !== 8'h00) begin
        errors++;
        $display("FAIL reset cyc%0d: valid=%b ready=%b id=%0d data=%h, need 0 0000 0 00",
                 i, out_valid, in_ready, out_id, out_data);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle: ready=%b valid=%b, need 0000 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    in_valid = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b need 0100", in_ready);
    end
    tick();
    in_valid = 4'b0000;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_id !== 2'd2) begin
      errors++;
      $display("FAIL single_out: valid=%b data=%h id=%0d, need 1 a5 2", out_valid, out_data, out_id);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_id !== 2'd2) begin
      errors++;
      $display("FAIL drain_hold: valid=%b data=%h id=%0d, need 0 a5 2", out_valid, out_data, out_id);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_g [5];
    logic [3:0] exp_r;
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 4'b1111; in_data = 32'h0403_0201; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_r = 4'b0001 << exp_g[i];
      checks++;
      if (in_ready !== exp_r) begin
        errors++;
        $display("FAIL rot_ready%0d: got %b need %b", i, in_ready, exp_r);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== exp_g[i] || out_data !== 8'(exp_g[i]) + 8'd1) begin
        errors++;
        $display("FAIL rot_out%0d: valid=%b id=%0d data=%h, need 1 %0d %h",
                 i, out_valid, out_id, out_data, exp_g[i], 8'(exp_g[i]) + 8'd1);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready%0d: got %b need 0000", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h01 || out_id !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h id=%0d, need 1 01 0", i, out_valid, out_data, out_id);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_ready: got %b need 0010", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h02 || out_id !== 2'd1) begin
      errors++;
      $display("FAIL bp_release: valid=%b data=%h id=%0d, need 1 02 1", out_valid, out_data, out_id);
    end
    tick();
    checks++;
    if (out_data !== 8'h03 || out_id !== 2'd2) begin
      errors++;
      $display("FAIL bp_next: data=%h id=%0d, need 03 2", out_data, out_id);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_wrap_skip();
    in_valid = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL skip_ready: got %b need 0010", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 8'h02) begin
      errors++;
      $display("FAIL skip_out: valid=%b id=%0d data=%h, need 1 1 02", out_valid, out_id, out_data);
    end
    in_valid = 4'b1000;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_ready: got %b need 1000", in_ready);
    end
    tick();
    checks++;
    if (out_id !== 2'd3 || out_data !== 8'h04) begin
      errors++;
      $display("FAIL wrap_out: id=%0d data=%h, need 3 04", out_id, out_data);
    end
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_ptr0: got %b need 0001", in_ready);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_id !== 2'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: valid=%b id=%0d data=%h, need 0 0 00", out_valid, out_id, out_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_ptr: got %b need 0001", in_ready);
    end
    in_valid = 4'b0000;
    out_ready = 1'b1;
    tick();
  endtask

`ifdef MUX_RR_ARBITER_PACKET_LOCK_EN
  task automatic test_lock();
    logic [7:0] words [3];
    words = '{8'h10, 8'h11, 8'h12};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'b0110;
      in_data  = {8'h00, 8'h20, words[i], 8'h00};
      in_last  = (i == 2) ? 4'b0010 : 4'b0000;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
        errors++;
        $display("FAIL lock_ready%0d: got %b need 0010", i, in_ready);
      end
      tick();
      checks++;
      if (out_id !== 2'd1 || out_data !== words[i]) begin
        errors++;
        $display("FAIL lock_out%0d: id=%0d data=%h, need 1 %h", i, out_id, out_data, words[i]);
      end
      if (i == 0) begin
        in_valid = 4'b0100;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
          errors++;
          $display("FAIL lock_stall: got %b need 0000", in_ready);
        end
        tick();
      end
    end
    in_valid = 4'b0110;
    in_last  = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL unlock_ready: got %b need 0100", in_ready);
    end
    tick();
    checks++;
    if (out_id !== 2'd2 || out_data !== 8'h20) begin
      errors++;
      $display("FAIL unlock_out: id=%0d data=%h, need 2 20", out_id, out_data);
    end
    in_valid = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap_skip();
    test_reset_midstream();
`ifdef MUX_RR_ARBITER_PACKET_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
